// File: rtl/counter_monitor.sv
// counter_monitor
// Checks that an upstream 4-bit counter steps +1 mod 16 and raises its carry
// exactly at 15. It locks after LOCK_N consecutive correct samples. While
// locked it counts errors (saturating) and 15->0 wraps. Each wrap is handed
// to a consumer as a snapshot over a valid/ready port.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   clear       synchronous pulse, zeroes the statistics
//   in_valid    qualifies cnt/cout this cycle
//   cnt, cout   upstream count value and carry
//   locked      tracking a correct sequence
//   err_flag    sticky, an error was seen while locked
//   err_count   errors seen while locked, saturating
//   wrap_count  wraps seen while locked, modulo 2^WRAP_W
//   snap_valid  snapshot available
//   snap_data   wrap_count value captured by the latest wrap
//   snap_ready  consumer accepts the snapshot
//   snap_ovf    sticky, a wrap overwrote an undrained snapshot
module counter_monitor #(
  parameter int WRAP_W = 16,
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [3:0]        cnt,
  input  logic              cout,
  output logic              locked,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              snap_valid,
  output logic [WRAP_W-1:0] snap_data,
  input  logic              snap_ready,
  output logic              snap_ovf
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  state_e              state_q, state_d;
  logic [3:0]          prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic [3:0]          match_q, match_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;
  logic                err_flag_q, err_flag_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic                snap_valid_q, snap_valid_d;
  logic [WRAP_W-1:0]   snap_data_q, snap_data_d;
  logic                snap_ovf_q, snap_ovf_d;

  logic [3:0]          prev_inc;
  logic [3:0]          match_inc;
  logic [WRAP_W-1:0]   wrap_inc;
  logic                sample_ok;
  logic                wrap_ev;
  logic                err_ev;
  logic                accept;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    match_d      = match_q;
    err_count_d  = err_count_q;
    err_flag_d   = err_flag_q;
    wrap_d       = wrap_q;
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    snap_ovf_d   = snap_ovf_q;
    wrap_ev      = 1'b0;
    err_ev       = 1'b0;

    prev_inc  = prev_q + 4'd1;
    match_inc = match_q + 4'd1;
    wrap_inc  = wrap_q + WRAP_W'(1);
    accept    = snap_valid_q && snap_ready;
    sample_ok = have_prev_q && (cnt == prev_inc) && (cout == (cnt == 4'hF));

    // Lock tracking and prev/match bookkeeping are unaffected by clear.
    if (in_valid) begin
      prev_d      = cnt;
      have_prev_d = 1'b1;
      unique case (state_q)
        UNLOCKED: begin
          if (sample_ok) begin
            if (match_inc == LOCK_V) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (!sample_ok) begin
            err_ev  = 1'b1;
            state_d = UNLOCKED;
            match_d = '0;
          end else if (prev_q == 4'hF) begin
            wrap_ev = 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    // Statistics: clear has priority and drops any event in the same cycle.
    if (clear) begin
      err_count_d  = '0;
      err_flag_d   = 1'b0;
      wrap_d       = '0;
      snap_ovf_d   = 1'b0;
      snap_valid_d = 1'b0;
    end else begin
      if (wrap_ev) begin
        wrap_d       = wrap_inc;
        snap_data_d  = wrap_inc;
        snap_valid_d = 1'b1;
        if (snap_valid_q && !snap_ready) begin
          snap_ovf_d = 1'b1;
        end
      end else if (accept) begin
        snap_valid_d = 1'b0;
      end
      if (err_ev) begin
        err_flag_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      match_q      <= '0;
      err_count_q  <= '0;
      err_flag_q   <= 1'b0;
      wrap_q       <= '0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
      snap_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      match_q      <= match_d;
      err_count_q  <= err_count_d;
      err_flag_q   <= err_flag_d;
      wrap_q       <= wrap_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
      snap_ovf_q   <= snap_ovf_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign snap_ovf   = snap_ovf_q;

endmodule

// File: tb/tb_counter_monitor.sv
module tb_counter_monitor;

  localparam int WRAP_W = 16;
  localparam int ERR_W  = 8;
  localparam int LOCK_N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              in_valid;
  logic [3:0]        cnt;
  logic              cout;
  logic              locked;
  logic              err_flag;
  logic [ERR_W-1:0]  err_count;
  logic [WRAP_W-1:0] wrap_count;
  logic              snap_valid;
  logic [WRAP_W-1:0] snap_data;
  logic              snap_ready;
  logic              snap_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers)
  int m_locked, m_prev, m_have_prev, m_match;
  int m_errs, m_flag, m_wraps, m_sv, m_sd, m_ovf;

  counter_monitor #(
    .WRAP_W(WRAP_W),
    .ERR_W (ERR_W),
    .LOCK_N(LOCK_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .cnt       (cnt),
    .cout      (cout),
    .locked    (locked),
    .err_flag  (err_flag),
    .err_count (err_count),
    .wrap_count(wrap_count),
    .snap_valid(snap_valid),
    .snap_data (snap_data),
    .snap_ready(snap_ready),
    .snap_ovf  (snap_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_prev = 0; m_have_prev = 0; m_match = 0;
    m_errs = 0; m_flag = 0; m_wraps = 0; m_sv = 0; m_sd = 0; m_ovf = 0;
  endtask

  // One clock of the behavioural model, using the inputs present at the edge.
  task automatic model_step();
    bit ok, wrap, err, acc;
    int c;
    wrap = 0; err = 0;
    acc  = (m_sv != 0) && snap_ready;
    c    = int'(cnt);
    if (in_valid) begin
      ok = (m_have_prev != 0) && (c == (m_prev + 1) % 16) && (cout == (c == 15));
      if (m_locked == 0) begin
        if (ok) begin
          m_match++;
          if (m_match == LOCK_N) begin
            m_locked = 1;
            m_match  = 0;
          end
        end else begin
          m_match = 0;
        end
      end else if (!ok) begin
        err = 1; m_locked = 0; m_match = 0;
      end else if (m_prev == 15 && c == 0) begin
        wrap = 1;
      end
      m_prev = c;
      m_have_prev = 1;
    end
    if (clear) begin
      m_errs = 0; m_flag = 0; m_wraps = 0; m_ovf = 0; m_sv = 0;
    end else begin
      if (wrap) begin
        m_wraps = (m_wraps + 1) % (1 << WRAP_W);
        if (m_sv != 0 && !snap_ready) m_ovf = 1;
        m_sd = m_wraps;
        m_sv = 1;
      end else if (acc) begin
        m_sv = 0;
      end
      if (err) begin
        m_flag = 1;
        if (m_errs < (1 << ERR_W) - 1) m_errs++;
      end
    end
  endtask

  task automatic compare_all();
    chk("locked",     32'(locked),     32'(m_locked));
    chk("err_flag",   32'(err_flag),   32'(m_flag));
    chk("err_count",  32'(err_count),  32'(m_errs));
    chk("wrap_count", 32'(wrap_count), 32'(m_wraps));
    chk("snap_valid", 32'(snap_valid), 32'(m_sv));
    chk("snap_ovf",   32'(snap_ovf),   32'(m_ovf));
    if (m_sv != 0) chk("snap_data", 32'(snap_data), 32'(m_sd));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic samp(input int c);
    in_valid = 1'b1;
    cnt      = 4'(c);
    cout     = (c == 15);
    cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cnt      = 4'($urandom);
    cout     = 1'($urandom);
    cycle();
  endtask

  initial begin
    int pulses;
    int wc0;
    int src;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; cnt = '0; cout = 1'b0;
    snap_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_wrap",   32'(wrap_count), 32'd0);
    chk("rst_snap",   32'({snap_valid, snap_ovf, err_flag}), 32'd0);
    reset = 1'b0;

    // Lock after reset: 3..7, locked after the fifth sample
    for (int c = 3; c <= 6; c++) samp(c);
    chk("lock_early", 32'(locked), 32'd0);
    samp(7);
    chk("lock_5th", 32'(locked), 32'd1);
    chk("lock_noerr", 32'(err_count), 32'd0);

    // Three wraps with the consumer always ready
    pulses = 0;
    for (int c = 8; c <= 15; c++) samp(c);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c <= 15; c++) begin
        samp(c);
        if (snap_valid) begin
          pulses++;
          chk("wrap_snapdata", 32'(snap_data), 32'(pulses));
        end
      end
    end
    chk("wrap_count3", 32'(wrap_count), 32'd3);
    chk("wrap_pulses", 32'(pulses), 32'd3);
    chk("wrap_noovf", 32'(snap_ovf), 32'd0);

    // Skip error 9 -> 11, then relock on 12..15
    for (int c = 0; c <= 9; c++) samp(c);
    samp(11);
    chk("skip_unlock", 32'(locked), 32'd0);
    chk("skip_errcnt", 32'(err_count), 32'd1);
    chk("skip_errflag", 32'(err_flag), 32'd1);
    for (int c = 12; c <= 15; c++) samp(c);
    chk("skip_relock", 32'(locked), 32'd1);

    // Bad carry at 15
    for (int c = 0; c <= 14; c++) samp(c);
    in_valid = 1'b1; cnt = 4'hF; cout = 1'b0;
    cycle();
    chk("carry_unlock", 32'(locked), 32'd0);
    chk("carry_errcnt", 32'(err_count), 32'd2);
    for (int c = 0; c <= 3; c++) samp(c);
    chk("carry_relock", 32'(locked), 32'd1);

    // Gap of 10 invalid cycles mid-sequence
    for (int c = 4; c <= 7; c++) samp(c);
    for (int i = 0; i < 10; i++) idle();
    samp(8);
    chk("gap_locked", 32'(locked), 32'd1);
    chk("gap_noerr", 32'(err_count), 32'd2);

    // Two wraps with consumer stalled -> overflow, latest value kept
    wc0 = int'(wrap_count);
    snap_ready = 1'b0;
    for (int c = 9; c <= 15; c++) samp(c);
    for (int c = 0; c <= 15; c++) samp(c);
    samp(0);
    chk("ovf_flag", 32'(snap_ovf), 32'd1);
    chk("ovf_data", 32'(snap_data), 32'(wc0 + 2));
    chk("ovf_valid", 32'(snap_valid), 32'd1);

    // Clear: statistics zero, lock kept
    clear = 1'b1;
    idle();
    clear = 1'b0;
    chk("clr_stats", 32'({err_flag, snap_ovf, snap_valid}), 32'd0);
    chk("clr_errcnt", 32'(err_count), 32'd0);
    chk("clr_wrap", 32'(wrap_count), 32'd0);
    chk("clr_locked", 32'(locked), 32'd1);
    snap_ready = 1'b1;

    // Asynchronous reset between edges while locked
    samp(1);
    samp(2);
    samp(3);
    #2 reset = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_all", 32'({err_flag, err_count, wrap_count, snap_valid, snap_data, snap_ovf}), 32'd0);
    model_reset();
    #1 reset = 1'b0;

    // Randomized phase: mostly well-formed sequence with glitches and gaps
    src = int'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      snap_ready = 1'($urandom);
      clear      = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        in_valid = 1'b1;
        cnt      = 4'(src);
        cout     = (src == 15);
        case ($urandom_range(0, 19))
          0: cnt  = 4'($urandom);
          1: cout = ~cout;
          default: ;
        endcase
        cycle();
        src = (src + 1) % 16;
      end
    end
    clear = 1'b0;

    // Error counter saturation: lock, fail, repeat
    snap_ready = 1'b1;
    clear = 1'b1;
    idle();
    clear = 1'b0;
    src = 0;
    samp(src);
    for (int k = 0; k < 260; k++) begin
      for (int j = 1; j <= LOCK_N; j++) samp((src + j) % 16);
      src = (src + LOCK_N + 2) % 16;
      samp(src);
    end
    chk("sat_errcnt", 32'(err_count), 32'd255);
    chk("sat_errflag", 32'(err_flag), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
